// File: rtl/multiplier_tree_pipe.sv
// Three-stage pipelined W x W multiplier (signed or unsigned per beat) with a
// global-stall valid/ready handshake and a sideband tag carried with each beat.
module multiplier_tree_pipe #(
    parameter int W     = 32,
    parameter int G     = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               signed_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int NG = W / G;
    localparam int PW = 2 * W;

    // -2^(W-1) maps to the unsigned pattern 2^(W-1), which fits W bits.
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] x, input logic sm);
        return (sm && x[W-1]) ? (~x + W'(1)) : x;
    endfunction

    function automatic logic [PW-1:0] cond_neg(input logic [PW-1:0] s, input logic n);
        return n ? (~s + PW'(1)) : s;
    endfunction

    logic               w_advance;

    logic               r_vld_p0;
    logic [W-1:0]       r_amag_p0;
    logic [W-1:0]       r_bmag_p0;
    logic               r_neg_p0;
    logic [TAG_W-1:0]   r_tag_p0;

    logic               r_vld_p1;
    logic [PW-1:0]      r_grp_p1 [NG];
    logic               r_neg_p1;
    logic [TAG_W-1:0]   r_tag_p1;

    logic               r_vld_p2;
    logic [PW-1:0]      r_prod_p2;
    logic [TAG_W-1:0]   r_tag_p2;

    logic [PW-1:0]      w_bext;
    logic [PW-1:0]      w_grp [NG];
    logic [PW-1:0]      w_sum;

    // The whole pipe stalls together; only the output register can block.
    assign w_advance = ~r_vld_p2 | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_vld_p2;
    assign product   = r_prod_p2;
    assign out_tag   = r_tag_p2;

    assign w_bext = {{W{1'b0}}, r_bmag_p0};

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            w_grp[g] = '0;
            for (int k = 0; k < G; k++) begin
                if (r_amag_p0[g*G + k]) begin
                    w_grp[g] = w_grp[g] + (w_bext << (g*G + k));
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int g = 0; g < NG; g++) begin
            w_sum = w_sum + r_grp_p1[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- Stage 1: sign/magnitude capture ----
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_amag_p0 <= mag_of(a, signed_mode);
            r_bmag_p0 <= mag_of(b, signed_mode);
            r_neg_p0  <= signed_mode & (a[W-1] ^ b[W-1]);
            r_tag_p0  <= in_tag;
        end
    end

    // ---- Stage 2: grouped partial-product sums ----
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int g = 0; g < NG; g++) begin
                r_grp_p1[g] <= w_grp[g];
            end
            r_neg_p1 <= r_neg_p0;
            r_tag_p1 <= r_tag_p0;
        end
    end

    // ---- Stage 3: final sum and conditional negation ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_p2 <= '0;
            r_tag_p2  <= '0;
        end else if (w_advance) begin
            r_prod_p2 <= cond_neg(w_sum, r_neg_p1);
            r_tag_p2  <= r_tag_p1;
        end
    end

endmodule

// File: tb/tb_multiplier_tree_pipe.sv
// Randomized and directed bench for multiplier_tree_pipe (W=8, G=4, TAG_W=4)
// with an arithmetic reference model and an in-order scoreboard.
module tb_multiplier_tree_pipe;

    localparam int W     = 8;
    localparam int G     = 4;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic               signed_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     product;
    logic [TAG_W-1:0]   out_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int n_in    = 0;
    int n_out   = 0;

    logic [2*W+TAG_W-1:0] exp_q [$];
    logic [2*W+TAG_W-1:0] mon_e;
    logic                 mon_have;

    multiplier_tree_pipe #(.W(W), .G(G), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: interpret operands as integers and multiply, keep 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic sm);
        longint px;
        longint py;
        px = longint'(x);
        py = longint'(y);
        if (sm && x[W-1]) px = px - (longint'(1) << W);
        if (sm && y[W-1]) py = py - (longint'(1) << W);
        return (2*W)'(px * py);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                            input logic [TAG_W-1:0] t, input logic [2*W-1:0] expp,
                            input string name);
        in_valid = 1'b1; a = x; b = y; signed_mode = sm; in_tag = t;
        step();
        in_valid = 1'b0;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        chk({name, "_lat2"}, 64'(out_valid), 64'd0);
        step();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_prod"}, 64'(product), 64'(expp));
        chk({name, "_tag"}, 64'(out_tag), 64'(t));
        step();
        chk({name, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    // Scoreboard: sample handshakes on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_have = (exp_q.size() > 0);
            chk("sb_has_beat", 64'(mon_have), 64'd1);
            if (mon_have) begin
                mon_e = exp_q.pop_front();
                chk("sb_prod", 64'(product), 64'(mon_e[2*W+TAG_W-1:TAG_W]));
                chk("sb_tag", 64'(out_tag), 64'(mon_e[TAG_W-1:0]));
                n_out++;
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back({ref_mul(a, b, signed_mode), in_tag});
            n_in++;
        end
    end

    initial begin
        int first;
        int last;
        int cnt;
        logic acc;
        logic [2*W-1:0]   hold_p;
        logic [TAG_W-1:0] hold_t;
        int sent;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        rst_n = 1'b1;
        step();

        one_beat(8'hFD, 8'h05, 1'b1, 4'h1, 16'hFFF1, "neg3x5");
        one_beat(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000, "minxmin");
        one_beat(8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01, "uffxff");
        one_beat(8'hFF, 8'hFF, 1'b1, 4'h4, 16'h0001, "sffxff");
        one_beat(8'h00, 8'h80, 1'b1, 4'h5, 16'h0000, "zero_neg");

        // Eight back-to-back random beats with mixed modes.
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
                signed_mode = 1'($urandom); in_tag = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("stream_cnt", 64'(cnt), 64'd8);
        chk("stream_run", 64'(last - first + 1), 64'd8);
        chk("stream_first", 64'(first), 64'd2);
        chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

        // Fill, stall for five cycles, then resume and drain.
        sent = 0;
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
        signed_mode = 1'($urandom); in_tag = 4'($urandom);
        hold_p = '0; hold_t = '0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 6 && c <= 10);
            #1;
            if (c == 6) begin
                hold_p = product;
                hold_t = out_tag;
                chk("stall_out_valid", 64'(out_valid), 64'd1);
            end
            if (c >= 6 && c <= 10) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_product", 64'(product), 64'(hold_p));
                chk("stall_out_tag", 64'(out_tag), 64'(hold_t));
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                sent++;
                if (sent < 12) begin
                    a = 8'($urandom); b = 8'($urandom);
                    signed_mode = 1'($urandom); in_tag = 4'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b1;
        chk("stall_sent", 64'(sent), 64'd12);
        chk("stall_q_empty", 64'(exp_q.size()), 64'd0);
        chk("inout_balance", 64'(n_out), 64'(n_in));

        // Three beats in flight, then asynchronous reset.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            signed_mode = 1'b0; in_tag = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_product", 64'(product), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        one_beat(8'h07, 8'h06, 1'b0, 4'h9, 16'h002A, "post_rst");
        repeat (3) step();
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_tree_pipe.md
MULTIPLIER_TREE_PIPE -- requirements
Module: multiplier_tree_pipe

Interface
REQ-001 Parameter W, default 32, operand width in bits; W SHALL be even and >= 4.
REQ-002 Parameter G, default 4, partial products summed per group in stage 2; W SHALL be a multiple of G.
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  W  multiplicand.
REQ-009 b  input  W  multiplier.
REQ-010 signed_mode  input  1  1 = a, b are two's complement; 0 = a, b are unsigned.
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-012 out_valid  output  1  product beat valid.
REQ-013 out_ready  input  1  downstream accepts a beat this cycle.
REQ-014 product  output  2*W  result: two's complement if signed_mode was 1, unsigned otherwise.
REQ-015 out_tag  output  TAG_W  in_tag of the same beat.

Function
REQ-016 The pipeline SHALL have 3 register stages: S1 = sign/magnitude capture, S2 = grouped partial-product sums, S3 = final sum and conditional negation.
REQ-017 S1 SHALL register |a|, |b| (magnitude taken only when signed_mode=1 and MSB=1) and neg = signed_mode & (a[W-1] ^ b[W-1]).
REQ-018 S2 SHALL form W partial products (a_mag[i] ? b_mag << i : 0) and register W/G sums, each 2*W bits, each summing G consecutive shifted partial products.
REQ-019 S3 SHALL add the W/G group sums and register product = neg ? two's complement of sum : sum.
REQ-020 Latency SHALL be exactly 3 cycles from the accepting edge (in_valid & in_ready) to out_valid when out_ready is held 1.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 advance = ~out_valid | out_ready; in_ready SHALL equal advance (combinational from out_valid, out_ready only, never from in_valid).
REQ-023 When advance=0, every stage register, valid bit and tag SHALL hold; no beat SHALL be dropped or duplicated.
REQ-024 Each stage SHALL carry a valid bit; a bubble (in_valid=0 on an advance cycle) SHALL propagate as valid=0.
REQ-025 product and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 signed_mode and in_tag SHALL be sampled per beat; mixed-mode back-to-back beats SHALL each use their own mode.
REQ-027 Signed a = b = -2^(W-1) SHALL yield +2^(2W-2) with no overflow; the magnitude of -2^(W-1) SHALL be held as unsigned W-bit 2^(W-1).
REQ-028 A zero operand SHALL yield product 0, including when neg=1 (no negative zero artefact).
REQ-029 All arithmetic SHALL be modulo 2^(2W); no truncation before S3.

Reset
REQ-030 While rst_n=0: all stage valid bits, out_valid, product and out_tag SHALL be 0; in_ready SHALL be 1.
REQ-031 Reset assertion mid-operation SHALL discard all in-flight beats immediately (asynchronous); the first beat after deassertion SHALL be handled normally.
REQ-032 Datapath registers other than valid bits and outputs need not be reset.

Verification (W=8, G=4, TAG_W=4)
REQ-033 Signed a=0xFD (-3), b=0x05, tag 0x1, out_ready=1 -> 3 cycles later out_valid=1, product=0xFFF1, out_tag=0x1.
REQ-034 Signed a=b=0x80 -> product=0x4000; unsigned a=b=0xFF -> product=0xFE01; signed a=0xFF, b=0xFF -> product=0x0001.
REQ-035 Stream 8 random beats with out_ready=1 -> 8 consecutive out_valid cycles, products and tags in order, matching a reference model.
REQ-036 Fill the pipe, drop out_ready for 5 cycles -> in_ready=0, product/out_tag stable, no loss; restore -> remaining beats emerge in order.
REQ-037 Assert rst_n=0 with 3 beats in flight -> out_valid=0, product=0 immediately; after release, a new beat 0x07*0x06 -> product=0x002A after 3 cycles.
REQ-038 Signed a=0x00, b=0x80 -> product=0x0000.
